// File: rtl/spi_flash_read_responder.sv
// spi_flash_read_responder: SPI mode 0/3 target answering flash READ (0x03) from a byte memory port.
// Define FLASH_RESP_JEDEC_ID_EN to also answer JEDEC ID (0x9F) with BF 25 49.
module spi_flash_read_responder #(
  parameter int ADDR_W      = 17,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_sys_clk,
  input  logic              i_reset,
  input  logic              i_spi_clk,
  input  logic              i_spi_cs_n,
  input  logic              i_spi_si,
  output logic              o_spi_so,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd,
  input  logic [7:0]        i_mem_data,
  output logic              o_busy,
  output logic              o_cmd_error
);

  localparam int SH_W = ADDR_W - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
`ifdef FLASH_RESP_JEDEC_ID_EN
    S_JEDEC,
`endif
    S_IGNORE
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] si_sync_q;
  logic sck_prev_q, cs_prev_q;
  logic sck_s, cs_s, si_s;
  logic sck_rise, sck_fall;
  logic cs_rise, cs_fall;

  logic [SH_W-1:0]   sh_q, sh_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0] addr_ptr_q, addr_ptr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic              rd_tx_q, rd_tx_d;
  logic              lat_q, lat_d;
  logic              lat_tx_q, lat_tx_d;
  logic [7:0]        tx_q, tx_d;
  logic [7:0]        nxt_q, nxt_d;
  logic [2:0]        obit_q, obit_d;
  logic              so_q, so_d;
  logic              cmd_err_q, cmd_err_d;

  logic [7:0]        opcode;
  logic [ADDR_W-1:0] rx_addr;
  logic              cmd_rd, cmd_jd;
  logic              last_cmd, last_addr;
  logic              sending;

`ifdef FLASH_RESP_JEDEC_ID_EN
  logic [1:0] jidx_q, jidx_d;

  function automatic logic [7:0] jedec_byte(
    input logic [1:0] idx
  );
    case (idx)
      2'd0:    return 8'hBF;
      2'd1:    return 8'h25;
      default: return 8'h49;
    endcase
  endfunction
`endif

  always_ff @(posedge i_sys_clk) begin
    sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], i_spi_clk};
    cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], i_spi_cs_n};
    si_sync_q  <= {si_sync_q[SYNC_STAGES-2:0], i_spi_si};
    sck_prev_q <= sck_s;
    cs_prev_q  <= cs_s;
  end

  assign sck_s = sck_sync_q[SYNC_STAGES-1];
  assign cs_s  = cs_sync_q[SYNC_STAGES-1];
  assign si_s  = si_sync_q[SYNC_STAGES-1];

  // CS release takes priority over any SCK edge seen in the same cycle
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;
  assign sck_rise = sck_s & ~sck_prev_q & ~cs_rise;
  assign sck_fall = ~sck_s & sck_prev_q & ~cs_rise;

  assign opcode  = {sh_q[6:0], si_s};
  assign rx_addr = {sh_q, si_s};
  assign cmd_rd  = opcode == 8'h03;
`ifdef FLASH_RESP_JEDEC_ID_EN
  assign cmd_jd  = opcode == 8'h9F;
  assign sending = (state_q == S_DATA || state_q == S_JEDEC)
                   && !cs_rise;
`else
  assign cmd_jd  = 1'b0;
  assign sending = state_q == S_DATA && !cs_rise;
`endif

  assign last_cmd  = state_q == S_CMD && sck_rise
                     && bit_cnt_q == 5'd7;
  assign last_addr = state_q == S_ADDR && sck_rise
                     && bit_cnt_q == 5'd23;

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (cs_fall) state_d = S_CMD;
        S_CMD: begin
          if (last_cmd) begin
            if (cmd_rd)      state_d = S_ADDR;
`ifdef FLASH_RESP_JEDEC_ID_EN
            else if (cmd_jd) state_d = S_JEDEC;
`endif
            else             state_d = S_IGNORE;
          end
        end
        S_ADDR: if (last_addr) state_d = S_DATA;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    o_busy      = state_q != S_IDLE;
    o_spi_so    = so_q;
    o_mem_addr  = mem_addr_q;
    o_mem_rd    = mem_rd_q;
    o_cmd_error = cmd_err_q;
  end

  always_comb begin
    sh_d       = sh_q;
    bit_cnt_d  = bit_cnt_q;
    addr_ptr_d = addr_ptr_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = 1'b0;
    rd_tx_d    = 1'b0;
    lat_d      = mem_rd_q;
    lat_tx_d   = rd_tx_q;
    tx_d       = tx_q;
    nxt_d      = nxt_q;
    obit_d     = obit_q;
    so_d       = so_q;
    cmd_err_d  = 1'b0;
`ifdef FLASH_RESP_JEDEC_ID_EN
    jidx_d     = jidx_q;
`endif
    // first byte of a burst goes straight out, later ones wait in nxt
    if (lat_q) begin
      if (lat_tx_q) tx_d  = i_mem_data;
      else          nxt_d = i_mem_data;
    end
    if (state_q == S_IDLE && cs_fall) bit_cnt_d = 5'd0;
    if (sck_rise && (state_q == S_CMD || state_q == S_ADDR)) begin
      sh_d      = {sh_q[SH_W-2:0], si_s};
      bit_cnt_d = bit_cnt_q + 5'd1;
    end
    if (last_cmd) begin
      bit_cnt_d = 5'd0;
      cmd_err_d = !(cmd_rd || cmd_jd);
`ifdef FLASH_RESP_JEDEC_ID_EN
      if (cmd_jd) begin
        tx_d   = 8'hBF;
        jidx_d = 2'd1;
        obit_d = 3'd7;
      end
`endif
    end
    if (last_addr) begin
      addr_ptr_d = rx_addr;
      mem_addr_d = rx_addr;
      mem_rd_d   = 1'b1;
      rd_tx_d    = 1'b1;
      obit_d     = 3'd7;
    end
    if (sending) begin
      if (sck_fall) begin
        so_d   = tx_q[obit_q];
        obit_d = obit_q - 3'd1;
        if (state_q == S_DATA && obit_q == 3'd7) begin
          addr_ptr_d = addr_ptr_q + ADDR_W'(1);
          mem_addr_d = addr_ptr_q + ADDR_W'(1);
          mem_rd_d   = 1'b1;
        end
      end
      if (sck_rise && obit_q == 3'd7) begin
`ifdef FLASH_RESP_JEDEC_ID_EN
        if (state_q == S_JEDEC) begin
          tx_d   = jedec_byte(jidx_q);
          jidx_d = (jidx_q == 2'd2) ? 2'd0 : jidx_q + 2'd1;
        end else begin
          tx_d = nxt_q;
        end
`else
        tx_d = nxt_q;
`endif
      end
    end else begin
      so_d = 1'b0;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      sh_q       <= '0;
      bit_cnt_q  <= '0;
      addr_ptr_q <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      rd_tx_q    <= 1'b0;
      lat_q      <= 1'b0;
      lat_tx_q   <= 1'b0;
      tx_q       <= '0;
      nxt_q      <= '0;
      obit_q     <= 3'd7;
      so_q       <= 1'b0;
      cmd_err_q  <= 1'b0;
`ifdef FLASH_RESP_JEDEC_ID_EN
      jidx_q     <= '0;
`endif
    end else begin
      sh_q       <= sh_d;
      bit_cnt_q  <= bit_cnt_d;
      addr_ptr_q <= addr_ptr_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      rd_tx_q    <= rd_tx_d;
      lat_q      <= lat_d;
      lat_tx_q   <= lat_tx_d;
      tx_q       <= tx_d;
      nxt_q      <= nxt_d;
      obit_q     <= obit_d;
      so_q       <= so_d;
      cmd_err_q  <= cmd_err_d;
`ifdef FLASH_RESP_JEDEC_ID_EN
      jidx_q     <= jidx_d;
`endif
    end
  end

endmodule
